fifo_word_reader: RTL and testbench
===================================

Name: fifo_word_reader

Overview:
- Consumer for the read side of the team's byte FIFO (8-bit data, read-control strobe, empty flag).
- Pops bytes whenever the FIFO is non-empty and packs them LSB-first into BYTES_PER_WORD-byte words.
- Presents each word on a valid/ready output handshake.
- Flushes a partial word with a byte-keep mask after the FIFO has stayed empty for TIMEOUT_CYCLES cycles.

Parameters:
- BYTES_PER_WORD, 4: bytes packed per output word; must be at least 2.
- TIMEOUT_CYCLES, 16: consecutive empty cycles with a partial word pending before a flush; must be at least 1.
- CNT_WIDTH, 16: width of the emitted-word counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_is_empty  in  1  FIFO empty flag.
- fifo_read_data  in  8  FIFO head byte; valid whenever fifo_is_empty=0 (first-word-fall-through).
- fifo_read_ctrl  out  1  pop strobe; the FIFO advances on the clk edge where this is 1.
- out_word  out  8*BYTES_PER_WORD  packed word; byte 0 is the first byte popped.
- out_keep  out  BYTES_PER_WORD  bit i=1 means byte i of out_word is valid.
- out_valid  out  1  word available.
- in_ready  in  1  downstream accepts the word when out_valid=1 and in_ready=1.
- out_word_count  out  CNT_WIDTH  number of words accepted downstream; wraps.

Behaviour:
- Reset values: fifo_read_ctrl=0, out_valid=0, out_word=0, out_keep=0, out_word_count=0. State=COLLECT, byte_idx=0, timeout counter=0.
- Reset mid-operation discards the partial word and any held word; no flush occurs.
- States: COLLECT and HOLD.
- fifo_read_ctrl = (state==COLLECT) & ~fifo_is_empty, combinational from registered state. It is never 1 while fifo_is_empty=1 and never 1 in HOLD.
- COLLECT, per pop:
  - fifo_read_data is stored into byte lane byte_idx.
  - byte_idx increments and the timeout counter clears.
  - If byte_idx was BYTES_PER_WORD-1: go to HOLD, out_keep=all ones, byte_idx=0.
  - Latency: out_valid rises the cycle after the final pop.
- COLLECT, FIFO empty and byte_idx>0:
  - The timeout counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 and the FIFO is still empty, go to HOLD next cycle.
  - out_keep = low byte_idx bits set; unused lanes are zero; byte_idx and the counter clear.
- COLLECT with byte_idx=0: the timeout counter holds at 0.
- HOLD:
  - out_valid=1; out_word and out_keep are stable until acceptance.
  - On in_ready=1, return to COLLECT and increment out_word_count (modulo 2^CNT_WIDTH).
  - Pops resume no earlier than the cycle after acceptance, so the minimum word period is BYTES_PER_WORD+1 cycles.
- In COLLECT, out_valid=0; out_word holds its last value. Lanes are overwritten as bytes arrive; stale lanes beyond out_keep are zeroed at flush.
- A byte arriving in the same cycle the timeout would expire counts as a pop: no flush that cycle, and the counter clears.
- in_ready while out_valid=0 is ignored.
- The counter widths are $clog2-sized to hold BYTES_PER_WORD and TIMEOUT_CYCLES without overflow.

Test Plan:
- Reset, then FIFO loaded with 11 22 33 44 (never empty) -> fifo_read_ctrl high 4 consecutive cycles, then out_word=0x44332211, out_keep=4'hF, out_valid next cycle. in_ready=1 -> out_word_count=1.
- Continuous 8 bytes 01..08 with in_ready held 0 for 5 cycles after the first word -> first word 0x04030201 held stable, fifo_read_ctrl=0 throughout HOLD. After acceptance, second word 0x08070605.
- 2 bytes AA BB then FIFO empty -> out_valid exactly TIMEOUT_CYCLES cycles after the second pop, with out_word=0x0000BBAA, out_keep=4'h3.
- Partial word with byte arriving on cycle TIMEOUT_CYCLES-1 of empty -> no flush; the counter restarts. Bench checks fifo_read_ctrl is never 1 while fifo_is_empty=1 for the whole test.
- rst asserted with 3 bytes collected, and separately while in HOLD -> out_valid=0, out_keep=0, out_word_count=0 next cycle. The next 4 bytes form a fresh full word.
- Preload out_word_count near wrap by accepting 2^CNT_WIDTH words (CNT_WIDTH=4 build, 16 words) -> count wraps to 0.

Source files
------------

// File: rtl/fifo_word_reader.sv
// Drains a first-word-fall-through byte FIFO and packs bytes LSB-first into words,
// flushing a partial word with a keep mask once the FIFO has idled long enough.
module fifo_word_reader #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_is_empty,
  input  logic [7:0]                    fifo_read_data,
  output logic                          fifo_read_ctrl,
  output logic [8*BYTES_PER_WORD-1:0]   out_word,
  output logic [BYTES_PER_WORD-1:0]     out_keep,
  output logic                          out_valid,
  input  logic                          in_ready,
  output logic [CNT_WIDTH-1:0]          out_word_count
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]                  state_reg, state_next;
  logic [IDX_W-1:0]            byte_idx_reg, byte_idx_next;
  logic [TO_W-1:0]             to_cnt_reg, to_cnt_next;
  logic [8*BYTES_PER_WORD-1:0] word_reg, word_next;
  logic [BYTES_PER_WORD-1:0]   keep_reg, keep_next;
  logic [BYTES_PER_WORD-1:0]   keep_flush;
  logic [CNT_WIDTH-1:0]        count_reg, count_next;

  logic pop;
  logic last_byte;
  logic timeout;

  // Popping is suppressed during reset so no byte is lost while the block is held.
  assign pop       = (state_reg == COLLECT) & ~fifo_is_empty & ~rst;
  assign last_byte = (byte_idx_reg == IDX_W'(BYTES_PER_WORD - 1));
  assign timeout   = (state_reg == COLLECT) & fifo_is_empty & (byte_idx_reg != '0)
                   & (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      // A lane takes the popped byte, or is cleared at flush if it lies beyond the partial word.
      assign word_next[gi*8 +: 8] =
        (pop && (byte_idx_reg == IDX_W'(gi)))     ? fifo_read_data :
        (timeout && (IDX_W'(gi) >= byte_idx_reg)) ? 8'h00 :
                                                    word_reg[gi*8 +: 8];
      assign keep_flush[gi] = (IDX_W'(gi) < byte_idx_reg);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    to_cnt_next   = to_cnt_reg;
    keep_next     = keep_reg;
    count_next    = count_reg;
    case (state_reg)
      COLLECT: begin
        if (pop) begin
          to_cnt_next = '0;
          if (last_byte) begin
            state_next    = HOLD;
            keep_next     = '1;
            byte_idx_next = '0;
          end else begin
            byte_idx_next = byte_idx_reg + IDX_W'(1);
          end
        end else if (timeout) begin
          state_next    = HOLD;
          keep_next     = keep_flush;
          byte_idx_next = '0;
          to_cnt_next   = '0;
        end else if (fifo_is_empty && (byte_idx_reg != '0)) begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      default: begin
        if (in_ready) begin
          state_next = COLLECT;
          count_next = count_reg + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= COLLECT;
      byte_idx_reg <= '0;
      to_cnt_reg   <= '0;
      word_reg     <= '0;
      keep_reg     <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      to_cnt_reg   <= to_cnt_next;
      word_reg     <= word_next;
      keep_reg     <= keep_next;
      count_reg    <= count_next;
    end
  end

  assign fifo_read_ctrl = pop;
  assign out_valid      = (state_reg == HOLD);
  assign out_word       = word_reg;
  assign out_keep       = keep_reg;
  assign out_word_count = count_reg;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: a queue models the FWFT FIFO, one task per scenario.
module tb_fifo_word_reader;
  localparam int BPW = 4;
  localparam int TO  = 16;
  localparam int CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           fifo_is_empty;
  logic [7:0]     fifo_read_data;
  logic           fifo_read_ctrl;
  logic [8*BPW-1:0] out_word;
  logic [BPW-1:0] out_keep;
  logic           out_valid;
  logic           in_ready;
  logic [CW-1:0]  out_word_count;

  fifo_word_reader #(.BYTES_PER_WORD(BPW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_is_empty(fifo_is_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_ctrl(fifo_read_ctrl), .out_word(out_word), .out_keep(out_keep),
    .out_valid(out_valid), .in_ready(in_ready), .out_word_count(out_word_count)
  );

  // Narrow-counter build used for the wrap check.
  logic        w_rst, w_empty, w_ctrl, w_valid, w_ready;
  logic [7:0]  w_data;
  logic [15:0] w_word;
  logic [1:0]  w_keep;
  logic [3:0]  w_count;

  fifo_word_reader #(.BYTES_PER_WORD(2), .TIMEOUT_CYCLES(2), .CNT_WIDTH(4)) dut_wrap (
    .clk(clk), .rst(w_rst), .fifo_is_empty(w_empty), .fifo_read_data(w_data),
    .fifo_read_ctrl(w_ctrl), .out_word(w_word), .out_keep(w_keep),
    .out_valid(w_valid), .in_ready(w_ready), .out_word_count(w_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] fq[$];
  logic [7:0] popped;
  logic       pre_ctrl;

  // One clock: present FIFO head, sample the pop strobe, pop on the edge, return at negedge.
  task automatic cyc();
    fifo_is_empty  = (fq.size() == 0);
    fifo_read_data = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    pre_ctrl = fifo_read_ctrl;
    if (fifo_is_empty) begin
      n_checks++;
      if (pre_ctrl !== 1'b0) begin
        n_fail++;
        $display("FAIL pop_while_empty: fifo_read_ctrl=%b required 0", pre_ctrl);
      end
    end
    @(posedge clk);
    if (pre_ctrl === 1'b1 && fq.size() != 0) popped = fq.pop_front();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fq.push_back(8'h77);
    cyc();
    n_checks++;
    if (pre_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: fifo_read_ctrl=%b required 0", pre_ctrl); end
    cyc();
    fq.delete();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: out_valid=%b required 0", out_valid); end
    n_checks++;
    if (out_word !== 32'h0) begin n_fail++; $display("FAIL reset_word: out_word=%h required 00000000", out_word); end
    n_checks++;
    if (out_keep !== 4'h0) begin n_fail++; $display("FAIL reset_keep: out_keep=%h required 0", out_keep); end
    n_checks++;
    if (out_word_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: count=%0d required 0", out_word_count); end
  endtask

  task automatic test_full_word();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (pre_ctrl !== 1'b1) begin n_fail++; $display("FAIL full_pop%0d: fifo_read_ctrl=%b required 1", i, pre_ctrl); end
      if (i == 2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: out_valid=%b required 0", out_valid); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: out_valid=%b required 1", out_valid); end
    n_checks++;
    if (out_word !== 32'h44332211) begin n_fail++; $display("FAIL full_word: out_word=%h required 44332211", out_word); end
    n_checks++;
    if (out_keep !== 4'hF) begin n_fail++; $display("FAIL full_keep: out_keep=%h required f", out_keep); end
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
    $display("word %h keep %h accepted", 32'h44332211, 4'hF);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_accept_valid: out_valid=%b required 0", out_valid); end
    n_checks++;
    if (out_word_count !== 16'd1) begin n_fail++; $display("FAIL full_count: count=%0d required 1", out_word_count); end
  endtask

  task automatic test_back_to_back();
    for (int b = 1; b <= 8; b++) fq.push_back(8'(b));
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if (out_word !== 32'h04030201 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: out_word=%h valid=%b required 04030201 valid 1", out_word, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (pre_ctrl !== 1'b0) begin n_fail++; $display("FAIL bp_hold_pop%0d: fifo_read_ctrl=%b required 0", i, pre_ctrl); end
      n_checks++;
      if (out_word !== 32'h04030201 || out_valid !== 1'b1 || out_keep !== 4'hF) begin
        n_fail++; $display("FAIL bp_hold%0d: out_word=%h valid=%b keep=%h required 04030201 1 f", i, out_word, out_valid, out_keep);
      end
    end
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
    $display("word %h keep %h accepted", 32'h04030201, 4'hF);
    n_checks++;
    if (pre_ctrl !== 1'b0) begin n_fail++; $display("FAIL bp_accept_pop: fifo_read_ctrl=%b required 0", pre_ctrl); end
    n_checks++;
    if (out_word_count !== 16'd2) begin n_fail++; $display("FAIL bp_count1: count=%0d required 2", out_word_count); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (pre_ctrl !== 1'b1) begin n_fail++; $display("FAIL bp_resume%0d: fifo_read_ctrl=%b required 1", i, pre_ctrl); end
    end
    n_checks++;
    if (out_word !== 32'h08070605 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: out_word=%h valid=%b required 08070605 valid 1", out_word, out_valid);
    end
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
    $display("word %h keep %h accepted", 32'h08070605, 4'hF);
    n_checks++;
    if (out_word_count !== 16'd3) begin n_fail++; $display("FAIL bp_count2: count=%0d required 3", out_word_count); end
  endtask

  task automatic test_timeout();
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    cyc(); cyc();
    for (int k = 1; k <= TO; k++) begin
      cyc();
      if (k == TO - 1) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: out_valid=%b required 0 at %0d", out_valid, k); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL to_valid: out_valid=%b required 1", out_valid); end
    n_checks++;
    if (out_word !== 32'h0000BBAA) begin n_fail++; $display("FAIL to_word: out_word=%h required 0000bbaa", out_word); end
    n_checks++;
    if (out_keep !== 4'h3) begin n_fail++; $display("FAIL to_keep: out_keep=%h required 3", out_keep); end
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
    $display("word %h keep %h accepted", 32'h0000BBAA, 4'h3);
    n_checks++;
    if (out_word_count !== 16'd4) begin n_fail++; $display("FAIL to_count: count=%0d required 4", out_word_count); end
  endtask

  task automatic test_late_byte();
    fq.push_back(8'hCC);
    cyc();
    for (int k = 1; k <= TO - 1; k++) cyc();
    fq.push_back(8'hDD);
    cyc();
    n_checks++;
    if (pre_ctrl !== 1'b1) begin n_fail++; $display("FAIL late_pop: fifo_read_ctrl=%b required 1", pre_ctrl); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL late_flush: out_valid=%b required 0", out_valid); end
    for (int k = 1; k <= TO; k++) begin
      cyc();
      if (k == TO - 1) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL late_restart: out_valid=%b required 0", out_valid); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h0000DDCC || out_keep !== 4'h3) begin
      n_fail++; $display("FAIL late_word: valid=%b word=%h keep=%h required 1 0000ddcc 3", out_valid, out_word, out_keep);
    end
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
    $display("word %h keep %h accepted", 32'h0000DDCC, 4'h3);
    n_checks++;
    if (out_word_count !== 16'd5) begin n_fail++; $display("FAIL late_count: count=%0d required 5", out_word_count); end
  endtask

  task automatic test_reset_mid();
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_keep !== 4'h0 || out_word_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_partial: valid=%b keep=%h count=%0d required 0 0 0", out_valid, out_keep, out_word_count);
    end
    for (int k = 0; k < TO + 2; k++) cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_flush: out_valid=%b required 0", out_valid); end
    fq.push_back(8'h5A); fq.push_back(8'h6B); fq.push_back(8'h7C); fq.push_back(8'h8D);
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h8D7C6B5A || out_keep !== 4'hF) begin
      n_fail++; $display("FAIL rst_fresh1: valid=%b word=%h keep=%h required 1 8d7c6b5a f", out_valid, out_word, out_keep);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_keep !== 4'h0 || out_word !== 32'h0 || out_word_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_hold: valid=%b keep=%h word=%h count=%0d required 0 0 0 0", out_valid, out_keep, out_word, out_word_count);
    end
    fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3); fq.push_back(8'hD4);
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hD4C3B2A1) begin
      n_fail++; $display("FAIL rst_fresh2: valid=%b word=%h required 1 d4c3b2a1", out_valid, out_word);
    end
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
    $display("word %h keep %h accepted", 32'hD4C3B2A1, 4'hF);
    n_checks++;
    if (out_word_count !== 16'd1) begin n_fail++; $display("FAIL rst_count: count=%0d required 1", out_word_count); end
  endtask

  task automatic test_wrap();
    w_rst = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      cyc();
      if (i == 1) begin
        n_checks++;
        if (w_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_first_valid: out_valid=%b required 0", w_valid); end
      end
      if (i == 2) begin
        n_checks++;
        if (w_valid !== 1'b1 || w_word !== 16'h5C5C || w_keep !== 2'b11) begin
          n_fail++; $display("FAIL wrap_word: valid=%b word=%h keep=%b required 1 5c5c 11", w_valid, w_word, w_keep);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (w_count !== 4'd1) begin n_fail++; $display("FAIL wrap_count1: count=%0d required 1", w_count); end
      end
      if (i == 45) begin
        n_checks++;
        if (w_count !== 4'd15) begin n_fail++; $display("FAIL wrap_count15: count=%0d required 15", w_count); end
      end
    end
    n_checks++;
    if (w_count !== 4'd0) begin n_fail++; $display("FAIL wrap_count0: count=%0d required 0", w_count); end
    $display("wrap build: 16 words accepted, count %0d", w_count);
    w_rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_ready = 1'b0;
    fifo_is_empty = 1'b1;
    fifo_read_data = 8'h00;
    w_rst = 1'b1;
    w_empty = 1'b0;
    w_data = 8'h5C;
    w_ready = 1'b1;
    popped = 8'h00;
    pre_ctrl = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_back_to_back();
    test_timeout();
    test_late_byte();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
